// File: rtl/debug_display_pkg.sv
// -----------------------------------------------------------------------------
// debug_display_pkg
//
// Shared definitions for the debug display viewer:
//   - DEFAULT_DEBOUNCE_CYCLES : button debounce length used when the top level
//                               does not override it
//   - SEG_0 .. SEG_F          : active-high seven-segment patterns for hex 0-F,
//                               segment a..g on bits 0..6
//   - hex_to_seg()            : nibble -> segment pattern (b and d lowercase)
// -----------------------------------------------------------------------------
package debug_display_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

  //                              gfedcba
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b1111100;
  localparam logic [6:0] SEG_C = 7'b0111001;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_F = 7'b1110001;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    seg = SEG_0;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Synchronises one raw active-low push-button and debounces it. A new level is
// accepted only after DEBOUNCE_CYCLES consecutive synchronised samples that all
// differ from the currently accepted level; any sample that agrees with the
// accepted level restarts the count. Accepting a pressed (0) level emits a
// single-cycle pulse; accepting a release emits nothing.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable samples needed to accept a level (>= 1)
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous active-low reset (button treated as released)
//   raw_ni           raw button level, active-low, asynchronous
//   pressed_pulse_o  one-cycle registered pulse on an accepted press
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_ni,
  output logic pressed_pulse_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // sync_q[1] is the metastability-safe sample; the counter only runs while it
  // disagrees with the accepted level, so a single agreeing sample clears it.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
        pulse_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], raw_ni};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pressed_pulse_o = pulse_q;

endmodule

// File: rtl/debug_display_mux.sv
// -----------------------------------------------------------------------------
// debug_display_mux
//
// Debug probe viewer. CHANNELS probe buses of WIDTH bits are presented on
// DIGITS seven-segment hex digits. Two debounced buttons step through the
// channel and through 4*DIGITS-bit windows of the selected value.
//
// Build option: define DEBUG_DISPLAY_HOLD_EN to add a hold button that freezes
// a snapshot of the selected channel. Without it no snapshot register or hold
// debouncer exists and hold_active_o is tied low.
//
// Parameters:
//   CHANNELS         number of probe buses (>= 1)
//   WIDTH            bits per probe, multiple of 4*DIGITS
//   DIGITS           hex digits displayed
//   DEBOUNCE_CYCLES  stable samples needed to accept a button level
// Ports:
//   clk_i               clock
//   rst_ni              asynchronous active-low reset
//   probe_i             channel c at [c*WIDTH +: WIDTH]
//   btn_next_channel_i  raw button, active-low
//   btn_next_window_i   raw button, active-low
//   btn_hold_i          raw button, active-low (only used with hold build)
//   hex_out_o           digit d at [7*d +: 7], segments a..g = bits 0..6, 1 = lit
//   channel_sel_o       current channel
//   window_sel_o        current window
//   hold_active_o       display is frozen on the snapshot
// -----------------------------------------------------------------------------
module debug_display_mux
  import debug_display_pkg::*;
#(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned WIDTH           = 64,
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  localparam int unsigned WINDOWS = WIDTH / (4 * DIGITS),
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned WIN_W   = (WINDOWS > 1) ? $clog2(WINDOWS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [CHANNELS*WIDTH-1:0] probe_i,
  input  logic                      btn_next_channel_i,
  input  logic                      btn_next_window_i,
  input  logic                      btn_hold_i,
  output logic [7*DIGITS-1:0]       hex_out_o,
  output logic [CH_W-1:0]           channel_sel_o,
  output logic [WIN_W-1:0]          window_sel_o,
  output logic                      hold_active_o
);

  localparam int unsigned WIN_BITS = 4 * DIGITS;
  // With a single channel/window the "last" value is 0, so the wrap below
  // naturally keeps the select at 0.
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOWS - 1);

  genvar gi;

  // ---------------------------------------------------------------------------
  // Buttons
  // ---------------------------------------------------------------------------
  logic next_ch_pulse;
  logic next_win_pulse;
  logic ch_blocked;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_channel (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .raw_ni         (btn_next_channel_i),
    .pressed_pulse_o(next_ch_pulse)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_window (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .raw_ni         (btn_next_window_i),
    .pressed_pulse_o(next_win_pulse)
  );

  // ---------------------------------------------------------------------------
  // Live channel selection
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] probe_ch [CHANNELS];
  logic [WIDTH-1:0] live_val;
  logic [WIDTH-1:0] disp_val;

  for (gi = 0; gi < CHANNELS; gi++) begin : g_probe
    assign probe_ch[gi] = probe_i[gi*WIDTH +: WIDTH];
  end

  logic [CH_W-1:0]  channel_q, channel_d;
  logic [WIN_W-1:0] window_q, window_d;

  assign live_val = probe_ch[channel_q];

  // ---------------------------------------------------------------------------
  // Optional hold / snapshot
  // ---------------------------------------------------------------------------
`ifdef DEBUG_DISPLAY_HOLD_EN
  logic             hold_pulse;
  logic             hold_q, hold_d;
  logic [WIDTH-1:0] snap_q, snap_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_hold (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .raw_ni         (btn_hold_i),
    .pressed_pulse_o(hold_pulse)
  );

  // The snapshot is taken on the same edge that enters hold, so it captures
  // exactly what the live display was about to show.
  always_comb begin
    hold_d = hold_q;
    snap_d = snap_q;
    if (hold_pulse) begin
      hold_d = ~hold_q;
      if (!hold_q) begin
        snap_d = live_val;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= 1'b0;
      snap_q <= '0;
    end else begin
      hold_q <= hold_d;
      snap_q <= snap_d;
    end
  end

  // Channel stepping is frozen while held, and a hold toggle in the same
  // cycle as next_channel takes priority.
  assign ch_blocked    = hold_q | hold_pulse;
  assign disp_val      = hold_q ? snap_q : live_val;
  assign hold_active_o = hold_q;
`else
  logic unused_btn_hold;
  assign unused_btn_hold = btn_hold_i;

  assign ch_blocked    = 1'b0;
  assign disp_val      = live_val;
  assign hold_active_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Channel / window selects
  // ---------------------------------------------------------------------------
  always_comb begin
    channel_d = channel_q;
    window_d  = window_q;
    if (next_ch_pulse && !ch_blocked) begin
      channel_d = (channel_q == CH_LAST) ? '0 : channel_q + 1'b1;
    end
    if (next_win_pulse) begin
      window_d = (window_q == WIN_LAST) ? '0 : window_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      channel_q <= '0;
      window_q  <= '0;
    end else begin
      channel_q <= channel_d;
      window_q  <= window_d;
    end
  end

  assign channel_sel_o = channel_q;
  assign window_sel_o  = window_q;

  // ---------------------------------------------------------------------------
  // Window extraction and segment encoding
  // ---------------------------------------------------------------------------
  logic [WIN_BITS-1:0] win_slice [WINDOWS];
  logic [WIN_BITS-1:0] cur_window;

  for (gi = 0; gi < WINDOWS; gi++) begin : g_window
    assign win_slice[gi] = disp_val[gi*WIN_BITS +: WIN_BITS];
  end

  assign cur_window = win_slice[window_q];

  logic [7*DIGITS-1:0] hex_q, hex_d;

  for (gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign hex_d[7*gi +: 7] = hex_to_seg(cur_window[4*gi +: 4]);
  end

  // Registered so the pins see one clean update per clock; reset blanks all
  // segments.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hex_q <= '0;
    end else begin
      hex_q <= hex_d;
    end
  end

  assign hex_out_o = hex_q;

endmodule

// File: tb/tb_debug_display_mux.sv
module tb_debug_display_mux;

  localparam int CH  = 4;
  localparam int W   = 64;
  localparam int D   = 4;
  localparam int DEB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   pv [4];
  logic [CH*W-1:0] probe;
  logic          b_ch = 1'b1;
  logic          b_win = 1'b1;
  logic          b_hold = 1'b1;
  logic [7*D-1:0] hex;
  logic [1:0]    ch_sel;
  logic [1:0]    win_sel;
  logic          hold;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign probe = {pv[3], pv[2], pv[1], pv[0]};

  debug_display_mux #(
    .CHANNELS       (CH),
    .WIDTH          (W),
    .DIGITS         (D),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .probe_i           (probe),
    .btn_next_channel_i(b_ch),
    .btn_next_window_i (b_win),
    .btn_hold_i        (b_hold),
    .hex_out_o         (hex),
    .channel_sel_o     (ch_sel),
    .window_sel_o      (win_sel),
    .hold_active_o     (hold)
  );

  // Reference seven-segment table, a..g = bit 0..6, 1 = lit.
  logic [6:0] seg_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [27:0] exp_hex(input logic [63:0] v, input int win);
    logic [27:0] r;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[7*d +: 7] = seg_tab[v[4*(win*4+d) +: 4]];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Hold the chosen buttons low long enough to be accepted, then release
  // long enough for the release to be accepted as well.
  task automatic press(input logic pc, input logic pw, input logic ph);
    @(negedge clk);
    b_ch = ~pc;
    b_win = ~pw;
    b_hold = ~ph;
    repeat (10) @(negedge clk);
    b_ch = 1'b1;
    b_win = 1'b1;
    b_hold = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  typedef struct {
    logic       pc;
    logic       pw;
    logic [1:0] ch;
    logic [1:0] win;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    pv[0] = 64'h0123_4567_89AB_CDEF;
    pv[1] = 64'hFEDC_BA98_7654_3210;
    pv[2] = 64'h0F1E_2D3C_4B5A_6978;
    pv[3] = 64'hDEAD_BEEF_CAFE_F00D;

    // {next_channel, next_window, expected channel, expected window}
    vecs[0]  = '{1'b0, 1'b1, 2'd1, 2'd1};
    vecs[1]  = '{1'b0, 1'b1, 2'd1, 2'd2};
    vecs[2]  = '{1'b0, 1'b1, 2'd1, 2'd3};
    vecs[3]  = '{1'b0, 1'b1, 2'd1, 2'd0};
    vecs[4]  = '{1'b1, 1'b0, 2'd2, 2'd0};
    vecs[5]  = '{1'b1, 1'b0, 2'd3, 2'd0};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 2'd0};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 2'd1};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 2'd2};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 2'd3};
    vecs[10] = '{1'b1, 1'b0, 2'd1, 2'd3};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 2'd3};
    vecs[12] = '{1'b1, 1'b0, 2'd3, 2'd3};
    vecs[13] = '{1'b1, 1'b1, 2'd0, 2'd0};

    // ---------------- reset ----------------
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hex", hex, 0);
    check("reset_ch", ch_sel, 0);
    check("reset_win", win_sel, 0);
    check("reset_hold", hold, 0);
    rst_n = 1'b1;
    #1;
    check("hex_before_first_edge", hex, 0);
    @(negedge clk);
    check("first_edge_digit0", hex[6:0], 7'h71);
    check("first_edge_hex", hex, exp_hex(pv[0], 0));
    $display("[TB] reset released: hex=%h ch=%0d win=%0d", hex, ch_sel, win_sel);

    // ---------------- probe -> hex latency ----------------
    pv[0] = 64'h0123_4567_89AB_1234;
    #1;
    check("latency_old", hex, exp_hex(64'h0123_4567_89AB_CDEF, 0));
    @(negedge clk);
    check("latency_new", hex, exp_hex(64'h0123_4567_89AB_1234, 0));
    $display("[TB] probe change: hex=%h", hex);

    // ---------------- bouncing next_channel ----------------
    for (int i = 0; i < 10; i++) begin
      b_ch = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clk);
    end
    check("bounce_no_pulse", ch_sel, 0);
    b_ch = 1'b0;
    repeat (6) @(negedge clk);
    check("bounce_not_yet", ch_sel, 0);
    @(negedge clk);
    check("bounce_accepted", ch_sel, 1);
    repeat (20) @(negedge clk);
    check("bounce_single_pulse", ch_sel, 1);
    b_ch = 1'b1;
    repeat (10) @(negedge clk);
    check("release_no_pulse", ch_sel, 1);
    $display("[TB] bounce press: ch=%0d win=%0d", ch_sel, win_sel);

    // ---------------- table-driven presses ----------------
    for (int i = 0; i < 14; i++) begin
      press(vecs[i].pc, vecs[i].pw, 1'b0);
      check($sformatf("vec%0d_ch", i), ch_sel, vecs[i].ch);
      check($sformatf("vec%0d_win", i), win_sel, vecs[i].win);
      check($sformatf("vec%0d_hex", i), hex, exp_hex(pv[vecs[i].ch], int'(vecs[i].win)));
      check($sformatf("vec%0d_hold", i), hold, 0);
      $display("[TB] vec %0d: ch=%0d win=%0d hex=%h", i, ch_sel, win_sel, hex);
    end

    // ---------------- hold feature ----------------
`ifdef DEBUG_DISPLAY_HOLD_EN
    press(1'b1, 1'b0, 1'b0);
    check("hold_pre_ch", ch_sel, 1);
    pv[1] = 64'hAAAA_AAAA_AAAA_AAAA;
    repeat (2) @(negedge clk);
    press(1'b0, 1'b0, 1'b1);
    check("hold_on", hold, 1);
    check("hold_on_hex", hex, exp_hex(64'hAAAA_AAAA_AAAA_AAAA, 0));
    $display("[TB] hold on: hold=%0d hex=%h", hold, hex);
    pv[1] = 64'h5555_5555_5555_5555;
    repeat (3) @(negedge clk);
    check("hold_frozen_hex", hex, exp_hex(64'hAAAA_AAAA_AAAA_AAAA, 0));
    press(1'b1, 1'b0, 1'b0);
    check("hold_ch_ignored", ch_sel, 1);
    check("hold_ch_hex", hex, exp_hex(64'hAAAA_AAAA_AAAA_AAAA, 0));
    press(1'b0, 1'b1, 1'b0);
    check("hold_win_pages", win_sel, 1);
    check("hold_win_hex", hex, exp_hex(64'hAAAA_AAAA_AAAA_AAAA, 1));
    $display("[TB] held paging: ch=%0d win=%0d hex=%h", ch_sel, win_sel, hex);
    @(negedge clk);
    b_hold = 1'b0;
    repeat (6) @(negedge clk);
    check("unhold_not_yet", hold, 1);
    @(negedge clk);
    check("unhold_flag", hold, 0);
    check("unhold_hex_lag", hex, exp_hex(64'hAAAA_AAAA_AAAA_AAAA, 1));
    @(negedge clk);
    check("unhold_hex_live", hex, exp_hex(64'h5555_5555_5555_5555, 1));
    b_hold = 1'b1;
    repeat (10) @(negedge clk);
    $display("[TB] hold off: hold=%0d hex=%h", hold, hex);
    press(1'b1, 1'b0, 1'b1);
    check("hold_wins_flag", hold, 1);
    check("hold_wins_ch", ch_sel, 1);
    $display("[TB] hold+channel: hold=%0d ch=%0d", hold, ch_sel);
`else
    press(1'b0, 1'b0, 1'b1);
    check("nohold_flag", hold, 0);
    check("nohold_hex", hex, exp_hex(pv[0], 0));
    $display("[TB] hold button without feature: hold=%0d", hold);
    press(1'b1, 1'b1, 1'b0);
    check("pre_reset_ch", ch_sel, 1);
    check("pre_reset_win", win_sel, 1);
`endif

    // ---------------- reset mid-debounce ----------------
    @(negedge clk);
    b_win = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_hex", hex, 0);
    check("midreset_ch", ch_sel, 0);
    check("midreset_win", win_sel, 0);
    check("midreset_hold", hold, 0);
    @(negedge clk);
    b_win = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("postreset_ch", ch_sel, 0);
    check("postreset_win", win_sel, 0);
    check("postreset_hold", hold, 0);
    check("postreset_hex", hex, exp_hex(pv[0], 0));
    $display("[TB] reset mid-debounce: ch=%0d win=%0d hold=%0d hex=%h", ch_sel, win_sel, hold, hex);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debug_display_mux.md
# debug_display_mux

Parametrised debug probe viewer for the board top level, replacing fixed one-decoder-per-bus wiring. Accepts CHANNELS probe buses of WIDTH bits, lets the user step through channels and 4·DIGITS-bit windows of the selected value with two debounced push-buttons, and drives DIGITS registered seven-segment digit patterns. An optional hold mode freezes a snapshot of the selected channel for inspection while the core keeps running.

## Interface
- CHANNELS, 4: number of probe buses; ≥1.
- WIDTH, 64: bits per probe; must be a multiple of 4·DIGITS.
- DIGITS, 4: hex digits displayed.
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised samples required to accept a button level.
- clock  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset.
- probe  in  CHANNELS·WIDTH  channel c occupies bits [c·WIDTH +: WIDTH]; asynchronous to nothing, sampled on clock.
- btn_next_channel  in  1  raw button, active-low (pressed = 0).
- btn_next_window  in  1  raw button, active-low.
- btn_hold  in  1  raw button, active-low; ignored unless the hold feature is compiled in.
- hex_out  out  7·DIGITS  digit d at [7·d +: 7], segment a..g = bit 0..6, active-high (1 = lit); top level inverts for the board.
- channel_sel  out  max(1,clog2(CHANNELS))  current channel.
- window_sel  out  max(1,clog2(WINDOWS))  current window, WINDOWS = WIDTH/(4·DIGITS).
- hold_active  out  1  1 while display is frozen.

## Operation
- Each button: 2-flop synchroniser, then debouncer; emits a one-cycle press pulse on accepted 1→0 transition of the raw level. Release generates nothing.
- next_channel pulse: channel_sel ← channel_sel+1, wrapping CHANNELS-1→0; window_sel unchanged.
- next_window pulse: window_sel ← window_sel+1, wrapping WINDOWS-1→0.
- Both pulses in the same cycle: both apply.
- Displayed value V = hold_active ? snapshot : probe channel channel_sel. Digit d shows nibble V[4·(window_sel·DIGITS+d) +: 4] as hex 0–F (b, d lowercase).
- CHANNELS=1 or WINDOWS=1: corresponding select stays 0; its pulses are no-ops.
- Reset (any time, including mid-debounce or mid-hold): channel_sel=0, window_sel=0, hold_active=0, snapshot=0, debounce counters cleared with button state "released", hex_out=0 (blank).

## Timing
- hex_out registered: reflects probe/selection sampled on the previous edge (1-cycle latency, probe to hex_out).
- Button: raw press → press pulse after 2 sync cycles + DEBOUNCE_CYCLES stable cycles; any bounce restarts the count. Select registers update on the edge after the pulse; hex_out one cycle after that.
- First rising edge after reset deasserts: hex_out shows channel 0, window 0.

## Configuration
- DEBUG_DISPLAY_HOLD_EN defined: hold press pulse toggles hold_active. On 0→1, snapshot ← current probe channel_sel (full WIDTH), same edge. While held: next_channel ignored, next_window pages through snapshot. On 1→0, live display resumes next cycle. Hold and next_channel in same cycle: hold wins, channel unchanged.
- Undefined: no snapshot register, btn_hold debouncer not instantiated, hold_active tied 0.

## Structure
- Package debug_display_pkg: 7-bit segment constants for 0–F, function hex_to_seg(nibble) returning active-high pattern, DEFAULT_DEBOUNCE_CYCLES constant.
- Sub-module button_debounce (params DEBOUNCE_CYCLES; ports clock, reset, raw_n, pressed_pulse), one instance per button.

## Test plan
(DEBOUNCE_CYCLES=4, CHANNELS=4, WIDTH=64, DIGITS=4.)
- Reset with probe ch0=0x0123_4567_89AB_CDEF → hex_out=0 during reset; one cycle after release digits show C,D,E,F (digit3..0), i.e. hex_out[6:0]=seg(F).
- Four next_window presses → window_sel 1,2,3,0; window 3 shows 0,1,2,3.
- btn_next_channel bouncing 0/1 every 2 cycles for 20 cycles, then held low → exactly one pulse, channel_sel 0→1, 6 cycles after stable low.
- Press both buttons in identical cycles at channel 3, window 3 → channel_sel=0, window_sel=0 together.
- (HOLD_EN) hold on ch1=0xAAAA…, then ch1 changes to 0x5555…, next_channel pressed → display stays A,A,A,A, channel_sel unchanged; hold again → 5,5,5,5 one cycle later.
- Assert reset while hold_active=1 and mid-debounce → all outputs 0, no stray pulse after release.
